// File: rtl/pll_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_pkg
// Description : Shared types and helpers for the PLL lock / reset supervisor.
//               State encoding, retry counter width and a helper that sizes
//               the shared cycle counter from the timing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_reset_pkg;

  // Supervisor states, 3-bit encoding
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_t;

  // Width of the saturating PLL retry counter
  localparam int RETRY_W = 8;

  // Counter width that can hold (largest parameter - 1); never below 1 bit
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic single-bit two-flop synchronizer with asynchronous
//               active-low clear. Output latency is two clk edges.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic stage1;

  // Two-stage capture of the asynchronous input into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= 1'b0;
      q      <= 1'b0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pll_lock_reset_gen.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_reset_gen
// Description : Power-up and lock supervisor for the iCE40 PLL. Drives the
//               PLL RESETB, qualifies the synchronized LOCK for a stable
//               period, then holds the system reset a little longer before
//               releasing it. Runs on the free-running reference clock.
//               Optional lock timeout with PLL re-reset and a saturating
//               retry counter is enabled by defining PLL_LOCK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_reset_gen
  import pll_reset_pkg::*;
#(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RESET_HOLD_CYCLES   = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pll_lock,
  output logic               pll_resetb,
  output logic               sys_rst_n,
  output logic               pll_ready
`ifdef PLL_LOCK_TIMEOUT_EN
  ,
  output logic [RETRY_W-1:0] retry_count
`endif
);

  localparam int CNT_W = cnt_width(PLL_RESET_CYCLES, LOCK_STABLE_CYCLES,
                                   RESET_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES);

  // Terminal counts for each timed state
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             lock_s;
`ifdef PLL_LOCK_TIMEOUT_EN
  logic             retry_inc;
`endif

  // LOCK is asynchronous to clk; the FSM only ever looks at lock_s
  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // State, shared counter and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= PLL_RST;
      cnt        <= '0;
      pll_resetb <= 1'b0;
      sys_rst_n  <= 1'b0;
      pll_ready  <= 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
      retry_count <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pll_resetb <= (state_nxt != PLL_RST);
      sys_rst_n  <= (state_nxt == RUN);
      pll_ready  <= (state_nxt == HOLD) || (state_nxt == RUN);
`ifdef PLL_LOCK_TIMEOUT_EN
      if (retry_inc && (retry_count != {RETRY_W{1'b1}}))
        retry_count <= retry_count + 1'b1;
`endif
    end
  end

  // Next-state logic; lock loss always takes priority over terminal count
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
`ifdef PLL_LOCK_TIMEOUT_EN
    retry_inc = 1'b0;
`endif
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
        end
`ifdef PLL_LOCK_TIMEOUT_EN
        else if (cnt == TIMEOUT_LAST) begin
          state_nxt = PLL_RST;
          retry_inc = 1'b1;
        end
`else
        else begin
          // No timeout: park the counter while waiting indefinitely
          cnt_nxt = '0;
        end
`endif
      end
      STABLE: begin
        if (!lock_s)                 state_nxt = WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_nxt = HOLD;
      end
      HOLD: begin
        if (!lock_s)               state_nxt = WAIT_LOCK;
        else if (cnt == HOLD_LAST) state_nxt = RUN;
      end
      RUN: begin
        // The PLL is left running on lock loss; only requalify
        if (!lock_s) state_nxt = WAIT_LOCK;
        else         cnt_nxt   = '0;
      end
      default: begin
        state_nxt = PLL_RST;
      end
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

endmodule
`default_nettype wire

// File: doc/pll_lock_reset_gen.md
Name: pll_lock_reset_gen

Overview:
Power-up and lock supervisor that sits directly downstream of the iCE40 PLL (SB_PLL40_CORE). It drives the PLL's active-low reset and consumes its LOCK output. It produces the system reset for all logic clocked from the PLL output. It runs on the free-running board reference clock, because the PLL output is not trustworthy until lock has been qualified.

Parameters:
PLL_RESET_CYCLES, 16, cycles pll_resetb is held low per PLL reset attempt (must be >= 1)
LOCK_STABLE_CYCLES, 1024, consecutive cycles lock must stay high before lock is trusted (>= 1)
RESET_HOLD_CYCLES, 64, extra cycles sys_rst_n stays low after lock is qualified (>= 1)
LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before the PLL is reset again (only used with the optional feature)

Ports:
clk  input  1  board reference clock, free-running; same net as the PLL REFERENCECLK
resetn  input  1  asynchronous active-low reset
pll_lock  input  1  PLL LOCK, asynchronous to clk
pll_resetb  output  1  drives PLL RESETB; low = PLL held in reset
sys_rst_n  output  1  active-low system reset; high only in RUN
pll_ready  output  1  high while lock is qualified (STABLE done, i.e. HOLD or RUN)
retry_count  output  8  PLL reset retries, saturating (only with PLL_LOCK_TIMEOUT_EN)

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low, named resetn. All flops are async-cleared by resetn.
- Reset values: state=PLL_RST, cnt=0, sync flops=0, pll_resetb=0, sys_rst_n=0, pll_ready=0, retry_count=0.
- Asserting resetn mid-operation forces all reset values immediately, without waiting for a clock edge.
- Lock synchronizer: 2-flop chain on pll_lock, output lock_s. Latency is 2 edges. Only lock_s is used by the FSM.
- All outputs are registered and are a direct function of the registered state.
- pll_resetb = (state != PLL_RST).
- sys_rst_n = (state == RUN).
- pll_ready = (state == HOLD || state == RUN).
- The counter cnt is shared across states and is cleared on every state transition. Its width is $clog2 of the largest parameter.
- PLL_RST: cnt increments each cycle. At cnt == PLL_RESET_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK: if lock_s, go to STABLE. Otherwise the timeout applies only if the feature is enabled; without it, wait indefinitely.
- STABLE: if !lock_s, go to WAIT_LOCK. Otherwise, at cnt == LOCK_STABLE_CYCLES-1, go to HOLD.
- HOLD: if !lock_s, go to WAIT_LOCK. Otherwise, at cnt == RESET_HOLD_CYCLES-1, go to RUN.
- RUN: if !lock_s, go to WAIT_LOCK. sys_rst_n is therefore low on the edge after lock_s falls. The PLL is not reset on lock loss.
- Simultaneous lock loss and counter terminal count: lock loss wins.
- Latency: if pll_lock is first sampled high at edge 0 with the FSM already in WAIT_LOCK, sys_rst_n rises after edge LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES+2.
- Glitch handling: a lock drop shorter than one clk period may be missed by the synchronizer. This is accepted.

Optional Feature:
Macro: PLL_LOCK_TIMEOUT_EN.
- Defined: in WAIT_LOCK, cnt counts up. At cnt == LOCK_TIMEOUT_CYCLES-1 with lock_s still low, go to PLL_RST and increment retry_count, saturating at 255. retry_count is cleared only by resetn. A lock arriving on the terminal-count cycle wins (go to STABLE).
- Undefined: no timeout. WAIT_LOCK holds indefinitely. The retry_count port is absent.

Decomposition:
- Package pll_reset_pkg holds:
  - the state_t enum {PLL_RST, WAIT_LOCK, STABLE, HOLD, RUN}, 3 bits;
  - the RETRY_W=8 constant;
  - a function giving cnt width from the parameters.
- One sub-module, sync_2ff: a generic single-bit 2-flop synchronizer with async active-low clear. It is reused by later clock-crossing blocks.

Test Plan:
All tests use PLL_RESET_CYCLES=2, LOCK_STABLE_CYCLES=4, RESET_HOLD_CYCLES=3, LOCK_TIMEOUT_CYCLES=10.
1. Release resetn, pll_lock=0 -> pll_resetb rises after edge 2; sys_rst_n and pll_ready stay 0.
2. After test 1, raise pll_lock at edge 0 -> pll_ready high after edge 6; sys_rst_n high after edge 9 (L+H+2).
3. In RUN, drop pll_lock for 5 cycles -> sys_rst_n low 3 edges after the drop, pll_resetb stays 1. Raise pll_lock again -> sys_rst_n re-rises 9 edges after lock is sampled.
4. In STABLE, drop pll_lock for 2 cycles at cnt=2 -> return to WAIT_LOCK; the full 4-cycle qualification restarts and no early sys_rst_n.
5. PLL_LOCK_TIMEOUT_EN, pll_lock held 0 -> pll_resetb low for 2 cycles every 12 cycles; retry_count 1,2,3…; after 300 timeouts retry_count=255.
6. Assert resetn low mid-HOLD, between clock edges -> pll_resetb, sys_rst_n, pll_ready go 0 immediately; retry_count clears to 0.
